// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and byte-enable constants for the loader
package imem_loader_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FINISH} state_e;
   localparam logic [3:0] WE_ALL  = 4'hF;
   localparam logic [3:0] WE_NONE = 4'h0;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams words into the instruction RAM debug port, then reads them back and checks a checksum
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] word_count,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic [31:0]      A2,
   output logic [31:0]      WD2,
   output logic [3:0]       WE2,
   input  logic [31:0]      RD2,
   output logic             busy,
   output logic             cpu_hold,
   output logic             done,
   output logic             error,
   output logic [31:0]      wr_sum
);
   state_e           state_q, state_d;
   logic [31:0]      base_q, base_d, wr_sum_q, wr_sum_d, rd_sum_q, rd_sum_d, addr;
   logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
   logic             pend_q, pend_d, error_q, error_d, busy_q, done_q;
   assign addr     = base_q + (32'(idx_q) << 2);
   assign busy     = busy_q;
   assign cpu_hold = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign wr_sum   = wr_sum_q;
   // state, index, checksums and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         base_q   <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         wr_sum_q <= '0;
         rd_sum_q <= '0;
         pend_q   <= 1'b0;
         error_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         wr_sum_q <= wr_sum_d;
         rd_sum_q <= rd_sum_d;
         pend_q   <= pend_d;
         error_q  <= error_d;
         busy_q   <= (state_d == WRITE) || (state_d == VERIFY);
         done_q   <= (state_q == FINISH);
      end
   end
   // next state plus the combinational debug-port drive
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      wr_sum_d = wr_sum_q;
      rd_sum_d = rd_sum_q;
      pend_d   = 1'b0;
      error_d  = error_q;
      in_ready = 1'b0;
      A2       = '0;
      WD2      = '0;
      WE2      = WE_NONE;
      unique case (state_q)
         IDLE: if (start) begin
            base_d   = base_addr & ~32'd3;
            cnt_d    = word_count;
            idx_d    = '0;
            wr_sum_d = '0;
            rd_sum_d = '0;
            error_d  = 1'b0;
            state_d  = (word_count != '0) ? WRITE : FINISH;
         end
         WRITE: begin
            in_ready = 1'b1;
            A2       = addr;
            if (in_valid) begin
               WD2      = in_data;
               WE2      = WE_ALL;
               wr_sum_d = wr_sum_q + in_data;
               idx_d    = (idx_q == cnt_q - 1'b1) ? '0 : idx_q + 1'b1;
               state_d  = (idx_q == cnt_q - 1'b1) ? VERIFY : WRITE;
            end
         end
         VERIFY: begin
            if (idx_q != cnt_q) begin
               A2     = addr;
               idx_d  = idx_q + 1'b1;
               pend_d = 1'b1;
            end
            // read data lags its address by one cycle
            if (pend_q) rd_sum_d = rd_sum_q + RD2;
            if (pend_q && idx_q == cnt_q) state_d = FINISH;
         end
         FINISH: begin
            error_d = error_q | (rd_sum_q != wr_sum_q);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Debug-side writer for the instruction RAM's second (debug) port: accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word addresses from a programmable base. It then reads the region back through the same port and checks a 32-bit additive checksum. It holds the CPU (`cpu_hold`) while loading, and is the producer for the A2/WD2/WE2/RD2 port of the IF-ID segment register's instruction RAM.

## Interface
- `CNT_W`, 16, width of the word-count input (max words = 2^CNT_W − 1)
- `clk` in 1: single clock, same as the CPU core
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle request; sampled only in IDLE
- `base_addr` in 32: byte address of the first word; bits [1:0] ignored (treated as 0)
- `word_count` in CNT_W: number of words to load; sampled with `start`
- `in_valid` in 1: stream word present
- `in_data` in 32: stream word
- `in_ready` out 1: loader accepts `in_data` this cycle
- `A2` out 32: debug-port byte address (word aligned)
- `WD2` out 32: debug-port write data
- `WE2` out 4: debug-port byte enables; 4'hF on write, else 4'h0
- `RD2` in 32: debug-port read data, valid one cycle after the address (synchronous BRAM)
- `busy` out 1: high in WRITE and VERIFY
- `cpu_hold` out 1: equals `busy`; the core is kept stalled or reset while it is high
- `done` out 1: one-cycle pulse at the end of an operation
- `error` out 1: sticky checksum-mismatch flag; cleared by the next accepted `start`
- `wr_sum` out 32: checksum of written words, held after done

## Operation
- States: IDLE, WRITE, VERIFY, FINISH.
- IDLE → WRITE on `start` when `word_count` ≠ 0. This latches `base_addr & ~3`, clears the index, `wr_sum` and `error`.
- IDLE → FINISH on `start` when `word_count` = 0. No port activity occurs and `error` stays 0.
- `start` outside IDLE is ignored.
- WRITE:
  - `in_ready` = 1.
  - When `in_valid`=1, the word is written the same cycle: `A2` = base + 4·idx, `WD2` = `in_data`, `WE2` = 4'hF. Then `wr_sum` += `in_data` (mod 2^32) and idx++.
  - When `in_valid`=0, `WE2` = 0 and nothing advances.
  - After the last word (idx = count−1 accepted) → VERIFY with idx reset to 0.
- VERIFY:
  - `in_ready` = 0 and `WE2` = 0.
  - One read address is issued per cycle: `A2` = base + 4·idx, for count cycles, with no stalls.
  - `RD2` from the previous cycle's address is accumulated into `rd_sum`, delayed by one cycle via a registered "read-pending" flag.
  - After the last read data is captured (count+1 cycles after entering VERIFY) → FINISH.
- FINISH:
  - `done` = 1 for exactly one cycle.
  - `error` is set if `rd_sum` ≠ `wr_sum`.
  - → IDLE.
- Address arithmetic is 32-bit and wraps modulo 2^32; no bounds check is made against RAM size.
- `A2` and `WD2` are 0 in IDLE and FINISH.

## Timing
- Reset values: state IDLE; `in_ready`, `busy`, `cpu_hold`, `done`, `error` = 0; `A2` = `WD2` = `wr_sum` = 0; `WE2` = 4'h0.
- `WE2`, `A2`, `WD2` and `in_ready` are combinational from state, index and `in_valid`. All other outputs are registered.
- Best-case latency for N words, from the `start` cycle to the `done` pulse: 1 (to WRITE) + N (writes) + N+1 (verify) + 1 = 2N+3 cycles.
- `rst` mid-operation: IDLE on the next edge. A partially written region is left as is. No `done` pulse; `error` is cleared.
- Read-during-write does not occur: WRITE and VERIFY never overlap.

## Structure
- Shared package `imem_loader_pkg`: the state enum (IDLE/WRITE/VERIFY/FINISH) and constants `WE_ALL = 4'hF` and `WE_NONE = 4'h0`.
- Single module; no sub-module needed. The checksum accumulators are two 32-bit registers inline.

## Test plan
- Load 3 words {0x00000013, 0x00100093, 0xFFFFFFFF} at base 0x0, `in_valid` always 1 → writes at A2 = 0x0, 0x4, 0x8 with WE2 = 4'hF; `done` at cycle 9 after `start`; `wr_sum` = 0x001000A5; `error` = 0; RAM contents match.
- Same load with `in_valid` deasserted for 2 cycles mid-stream → WE2 = 0 in those cycles, no index advance, `done` 2 cycles later, identical RAM contents.
- Bench corrupts RAM word 1 (forces RD2 = 0 on its readback) → `error` = 1 at `done`, and stays 1 until the next `start`.
- `word_count` = 0 → no WE2 activity, `done` 2 cycles after `start`, `busy` never high.
- `base_addr` = 0xFFFFFFFE, 2 words → addresses 0xFFFFFFFC then 0x00000000; `start` pulsed during WRITE is ignored.
- `rst` asserted in the 2nd WRITE cycle → next cycle IDLE, `busy` = 0, WE2 = 0, no `done`.
